// File: rtl/muldiv_pkg.sv
// Shared encodings for the RISC-V M-extension multiply/divide unit:
// funct3 op codes, controller states and operand-signedness helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} register pair: shift-add for
// multiply (lo holds the multiplier), restoring shift-subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = shifted >= {1'b0, m_i};
    if (is_div_i) begin
      // partial remainder stays below the divisor, so XLEN bits suffice
      hi_o = ge ? (shifted[XLEN-1:0] - m_i) : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, UNROLL radix-2 steps per clock.
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating on magnitudes, counter counts down to 0
// FIX   | sign correction and half/quotient/remainder select
// DONE  | result valid for one cycle, may accept a back-to-back start
module rv_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (XLEN % UNROLL != 0) begin : g_bad_unroll
    $error("rv_muldiv_unit: XLEN must be a multiple of UNROLL");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;

  op_e             op_in;
  logic            neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] qr, qr_fix, fix_res;
  logic [XLEN-1:0] hi_step, lo_step;
  logic            is_div_q;

  assign is_div_q = op_is_div(op_q);

  for (genvar i = 0; i < UNROLL; i++) begin : g_chain
    logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;
    if (i == 0) begin : g_head
      assign hi_in = hi_q;
      assign lo_in = lo_q;
    end else begin : g_link
      assign hi_in = g_chain[i-1].hi_out;
      assign lo_in = g_chain[i-1].lo_out;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (is_div_q),
      .hi_i     (hi_in),
      .lo_i     (lo_in),
      .m_i      (m_q),
      .hi_o     (hi_out),
      .lo_o     (lo_out)
    );
  end

  assign hi_step = g_chain[UNROLL-1].hi_out;
  assign lo_step = g_chain[UNROLL-1].lo_out;

  always_comb begin
    op_in    = op_e'(funct3);
    neg_a    = op_a_signed(op_in) & op_a[XLEN-1];
    neg_b    = op_b_signed(op_in) & op_b[XLEN-1];
    abs_a    = neg_a ? -op_a : op_a;
    abs_b    = neg_b ? -op_b : op_b;
    div_zero = op_is_div(op_in) && (op_b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (op_a == MIN_NEG) && (op_b == '1);
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    qr       = op_is_rem(op_q) ? hi_q : lo_q;
    qr_fix   = neg_q ? -qr : qr;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      default:                     fix_res = qr_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !kill) begin
          op_d  = op_in;
          hi_d  = '0;
          lo_d  = abs_a;
          m_d   = abs_b;
          neg_d = op_is_rem(op_in) ? neg_a : (neg_a ^ neg_b);
          if (div_zero) begin
            result_d = op_is_rem(op_in) ? op_a : '1;
            cnt_d    = '0;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op_is_rem(op_in) ? '0 : op_a;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(N);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // a flush wins over everything, including a same-cycle start
    if (kill) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: UNROLL=1 and UNROLL=4 instances checked against
// an arithmetic reference model with directed and random operations.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
  logic [31:0] last_res1, last_res4;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .kill(kill), .busy(busy1), .done(done1), .result(res1)
  );

  rv_muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .kill(kill), .busy(busy4), .done(done4), .result(res4)
  );

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dirv [13] = '{
    '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000},
    '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
    '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
    '{3'b101, 32'd100,        32'd7,        32'd14},
    '{3'b111, 32'd100,        32'd7,        32'd2},
    '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF},
    '{3'b110, 32'd5,          32'd0,        32'd5},
    '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000},
    '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0},
    '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'b010, 32'd2,          32'hFFFFFFFF, 32'd1}
  };

  logic [31:0] specials [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic logic is_bypass(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'b000: p = sa * sb;
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return a;
        p = sa / sb;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cycle c is the c-th cycle after the accepting edge; sampled at negedge
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    logic byp;
    int   lat1, lat4;
    byp  = is_bypass(f, a, b);
    lat1 = byp ? 1 : 34;
    lat4 = byp ? 1 : 10;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start1 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      check($sformatf("%s u1 busy c%0d", name, c), 32'(busy1), 32'(!byp && c <= 33));
      check($sformatf("%s u1 done c%0d", name, c), 32'(done1), 32'(c == lat1));
      check($sformatf("%s u4 busy c%0d", name, c), 32'(busy4), 32'(!byp && c <= 9));
      check($sformatf("%s u4 done c%0d", name, c), 32'(done4), 32'(c == lat4));
      if (c >= lat1) check($sformatf("%s u1 result c%0d", name, c), res1, exp);
      if (c >= lat4) check($sformatf("%s u4 result c%0d", name, c), res4, exp);
      if (c == 1) begin start1 = 1'b0; start4 = 1'b0; end
      if (!byp && c == 4) begin
        start1 = 1'b1; start4 = 1'b1;
        funct3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
      end
      if (c == 5) begin start1 = 1'b0; start4 = 1'b0; end
    end
    last_res1 = exp;
    last_res4 = exp;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; kill = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0;
    last_res1 = '0; last_res4 = '0;

    #1;
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    check("reset result1", res1, 32'd0);
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset result4", res4, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset done1", 32'(done1), 32'd0);
    check("post-reset done4", 32'(done4), 32'd0);

    for (int i = 0; i < 13; i++)
      run_op(dirv[i].f, dirv[i].a, dirv[i].b, dirv[i].e, $sformatf("dir%0d", i));

    // kill mid-MUL on the UNROLL=1 unit only
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd5; start1 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("kill busy1 c%0d", c), 32'(busy1), 32'(c <= 10));
      check($sformatf("kill done1 c%0d", c), 32'(done1), 32'd0);
      check($sformatf("kill result1 c%0d", c), res1, last_res1);
      check($sformatf("kill busy4 c%0d", c), 32'(busy4), 32'd0);
      check($sformatf("kill result4 c%0d", c), res4, last_res4);
      if (c == 1) start1 = 1'b0;
      if (c == 10) kill = 1'b1;
      if (c == 11) kill = 1'b0;
    end
    run_op(3'b000, 32'd7, 32'd5, 32'd35, "after-kill");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rnd%0d f%0d", i, rf));
    end

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start1 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("pre-rst busy1 c%0d", c), 32'(busy1), 32'd1);
      check($sformatf("pre-rst busy4 c%0d", c), 32'(busy4), 32'd1);
      if (c == 1) begin start1 = 1'b0; start4 = 1'b0; end
    end
    #2 rst = 1'b1;
    #1;
    check("async rst busy1", 32'(busy1), 32'd0);
    check("async rst busy4", 32'(busy4), 32'd0);
    check("async rst done1", 32'(done1), 32'd0);
    check("async rst result1", res1, 32'd0);
    check("async rst result4", res4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("after rst done1 c%0d", c), 32'(done1), 32'd0);
      check($sformatf("after rst done4 c%0d", c), 32'(done4), 32'd0);
      check($sformatf("after rst busy1 c%0d", c), 32'(busy1), 32'd0);
    end
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "rerun div");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 SHALL have parameter UNROLL, default 1: radix-2 iterations per clock; XLEN % UNROLL == 0 required, else elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request strobe, sampled when busy=0.
REQ-006 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports op_a, op_b  input  XLEN each  rs1/rs2 operands, sampled with start.
REQ-008 SHALL have port kill  input  1  abort the in-flight op (pipeline flush).
REQ-009 SHALL have port busy  output  1  op in flight; the core holds PC while busy or start pending.
REQ-010 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-011 SHALL have port result  output  XLEN  result, held stable from done until next accepted start.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE; busy=1 in CALC and FIX.
REQ-013 SHALL accept start only in IDLE or DONE with kill=0; it latches funct3, op_a, op_b, takes absolute values for signed operands, and enters CALC with iteration counter N=XLEN/UNROLL.
REQ-014 SHALL perform UNROLL shift-add (multiply) or restoring shift-subtract (divide) steps per CALC cycle, decrementing the counter by 1; CALC is left for FIX when the counter reaches 0.
REQ-015 SHALL apply sign correction and select the low/high product half or the quotient/remainder in FIX, then enter DONE.
REQ-016 SHALL assert done exactly N+2 cycles after the accepting edge (34 for XLEN=32, UNROLL=1); DONE lasts one cycle, then IDLE unless a new start is accepted.
REQ-017 SHALL use a 2*XLEN product; MULHSU treats op_a as signed and op_b as unsigned; MUL returns the low XLEN bits regardless of signedness.
REQ-018 SHALL, for divide by zero, bypass CALC: quotient all-ones, remainder = op_a, done 1 cycle after accept.
REQ-019 SHALL, for signed overflow (op_a = 1 followed by zeros, op_b = all-ones), bypass CALC: quotient = op_a, remainder 0, done 1 cycle after accept.
REQ-020 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-021 SHALL ignore start while busy=1; no queueing.
REQ-022 SHALL, on kill, move to IDLE at the next edge with no done pulse and result unchanged; kill with start in the same cycle drops the start.

Reset
REQ-023 SHALL, on rst, immediately force IDLE with busy=0, done=0, result=0 and counter=0, including mid-operation.
REQ-024 SHALL not pulse done on the first edge after rst deasserts.

Structure
REQ-025 SHALL define the funct3 op encodings and the state enum in shared package muldiv_pkg.
REQ-026 SHALL contain one sub-module, muldiv_step: a combinational single radix-2 iteration (add/subtract + shift), instantiated UNROLL times in a chain.

Verification
REQ-027 SHALL cover: MUL 7 x -3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done at cycle 34, busy high for cycles 1-33.
REQ-028 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-030 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done 1 cycle after accept; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-031 SHALL cover: kill at cycle 10 of MUL -> IDLE next cycle, no done, result unchanged; a new start is then accepted normally.
REQ-032 SHALL cover: rst asserted asynchronously mid-DIV -> busy=0 immediately, no done, then the UNROLL=4 rerun of DIV -7/2 gives done at cycle 10.
